dmem_port_arbiter: RTL



---
 rtl/dmem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one data-memory port between two requesters (0: memory-access
//   stage, 1: debug/load master). Round-robin grant, address range check,
//   one outstanding memory transaction with ack timeout, one-cycle done
//   pulse back to the granted requester.
// Ports
//   clk_i, rst_n_i                  clock, synchronous active-low reset
//   rN_req_i/we_i/addr_i/wdata_i    requester N request (held until done)
//   rN_done_o/rdata_o/err_o         requester N completion pulse + data/status
//   m_req_o/we_o/addr_o/wdata_o     memory request (stable while busy)
//   m_ack_i/rdata_i/err_i           memory completion
//   busy_o                          high whenever not idle
module dmem_port_arbiter #(
  parameter int MEM_BYTES = 8192,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        r0_req_i,
  input  logic        r1_req_i,
  input  logic        r0_we_i,
  input  logic        r1_we_i,
  input  logic [63:0] r0_addr_i,
  input  logic [63:0] r1_addr_i,
  input  logic [63:0] r0_wdata_i,
  input  logic [63:0] r1_wdata_i,
  output logic        r0_done_o,
  output logic        r1_done_o,
  output logic [63:0] r0_rdata_o,
  output logic [63:0] r1_rdata_o,
  output logic        r0_err_o,
  output logic        r1_err_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [63:0] m_addr_o,
  output logic [63:0] m_wdata_o,
  input  logic        m_ack_i,
  input  logic [63:0] m_rdata_i,
  input  logic        m_err_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  localparam logic [63:0] MAX_ADDR  = 64'(MEM_BYTES - 8);
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              sel_q, sel_d;
  logic              oor_q, oor_d;
  req_t              req_q, req_d;
  logic [7:0]        wait_q, wait_d;

  logic              gnt;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;

  logic              m_req_q, m_req_d;
  logic              busy_q, busy_d;
  logic [1:0]        done_q, done_d;
  logic [1:0][63:0]  rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;   // requester 0 wins the first tie
      sel_q      <= 1'b0;
      oor_q      <= 1'b0;
      req_q      <= '0;
      wait_q     <= '0;
      m_req_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      sel_q      <= sel_d;
      oor_q      <= oor_d;
      req_q      <= req_d;
      wait_q     <= wait_d;
      m_req_q    <= m_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    oor_d      = oor_q;
    req_d      = req_q;
    wait_d     = wait_q;
    gnt        = 1'b0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (r0_req_i | r1_req_i) begin
          // r1 wins when alone, or on a tie when r0 had the last grant
          gnt        = r1_req_i & (~r0_req_i | ~last_gnt_q);
          sel_d      = gnt;
          last_gnt_d = gnt;
          req_d.we    = gnt ? r1_we_i    : r0_we_i;
          req_d.addr  = gnt ? r1_addr_i  : r0_addr_i;
          req_d.wdata = gnt ? r1_wdata_i : r0_wdata_i;
          oor_d      = (gnt ? r1_addr_i : r0_addr_i) > MAX_ADDR;
          wait_d     = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // An out-of-range access spends its BUSY cycle without m_req
        if (oor_q) begin
          rsp_err = 1'b1;
          state_d = RESP;
        end else if (m_ack_i) begin
          rsp_rdata = req_q.we ? '0 : m_rdata_i;
          rsp_err   = m_err_i;
          state_d   = RESP;
        end else if (wait_q == WAIT_LAST) begin
          rsp_err = 1'b1;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values, derived from the next state so outputs are registered
  always_comb begin
    m_req_d = (state_d == BUSY) & ~oor_d;
    busy_d  = (state_d != IDLE);
    done_d  = '0;
    rdata_d = '0;
    err_d   = '0;
    if (state_d == RESP) begin
      done_d[sel_d]  = 1'b1;
      rdata_d[sel_d] = rsp_rdata;
      err_d[sel_d]   = rsp_err;
    end
  end

  assign m_req_o    = m_req_q;
  assign m_we_o     = req_q.we;
  assign m_addr_o   = req_q.addr;
  assign m_wdata_o  = req_q.wdata;
  assign busy_o     = busy_q;
  assign r0_done_o  = done_q[0];
  assign r1_done_o  = done_q[1];
  assign r0_rdata_o = rdata_q[0];
  assign r1_rdata_o = rdata_q[1];
  assign r0_err_o   = err_q[0];
  assign r1_err_o   = err_q[1];

endmodule
